thd_harm_scan: RTL



---
 rtl/thd_harm_scan_pkg.sv | 35 +++
 rtl/thd_harm_scan_if.sv | 39 +++
 rtl/thd_harm_scan_sq.sv | 37 +++
 rtl/thd_harm_scan.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/thd_harm_scan_pkg.sv
// thd_pkg: shared types and sizing helpers for the THD harmonic scanner.
//   - thd_state_e      : scanner FSM states
//   - THD_* constants  : default geometry (RAM address/data widths, N/2,
//                        power and accumulator widths)
//   - thd_pwr_width()  : width of a squared magnitude
//   - thd_acc_width()  : width of the harmonic power accumulator
package thd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FSCAN = 3'd1,
        ST_FSQ   = 3'd2,
        ST_HSET  = 3'd3,
        ST_HSCAN = 3'd4,
        ST_HACC  = 3'd5,
        ST_DONE  = 3'd6
    } thd_state_e;

    localparam int THD_ADDR_WIDTH = 11;
    localparam int THD_DATA_WIDTH = 32;
    localparam int THD_HALF_N     = 32'sd1 << (THD_ADDR_WIDTH - 1);
    localparam int THD_PWR_WIDTH  = 2 * THD_DATA_WIDTH;
    localparam int THD_ACC_WIDTH  = THD_PWR_WIDTH + 4;

    // Squared magnitude width.
    function automatic int thd_pwr_width(input int data_width);
        return 2 * data_width;
    endfunction

    // Harmonic sum width: four guard bits hold up to nine full-scale squares.
    function automatic int thd_acc_width(input int data_width);
        return 2 * data_width + 4;
    endfunction

endpackage

// File: rtl/thd_harm_scan_if.sv
// thd_harm_scan_if: request/result and RAM read-port signals of the scanner.
//   start    : one-cycle scan request
//   busy     : scan in progress
//   done     : one-cycle completion pulse, results valid from this cycle
//   rd_addr  : spectrum RAM read address
//   rd_data  : RAM data for the address issued one cycle earlier
//   fund_bin : fundamental bin index
//   fund_pwr : fundamental magnitude squared
//   harm_pwr : sum of squared harmonic peaks
//   harm_cnt : number of harmonics summed
// Modports: master = requester + RAM model side, slave = scanner side.
interface thd_harm_scan_if
    import thd_pkg::*;
#(
    parameter int ADDR_WIDTH = THD_ADDR_WIDTH,
    parameter int DATA_WIDTH = THD_DATA_WIDTH
) ();

    logic                                    start;
    logic                                    busy;
    logic                                    done;
    logic [ADDR_WIDTH-1:0]                   rd_addr;
    logic [DATA_WIDTH-1:0]                   rd_data;
    logic [ADDR_WIDTH-1:0]                   fund_bin;
    logic [thd_pwr_width(DATA_WIDTH)-1:0]    fund_pwr;
    logic [thd_acc_width(DATA_WIDTH)-1:0]    harm_pwr;
    logic [3:0]                              harm_cnt;

    modport master (
        output start, rd_data,
        input  busy, done, rd_addr, fund_bin, fund_pwr, harm_pwr, harm_cnt
    );

    modport slave (
        input  start, rd_data,
        output busy, done, rd_addr, fund_bin, fund_pwr, harm_pwr, harm_cnt
    );

endinterface

// File: rtl/thd_harm_scan_sq.sv
// thd_sq: unsigned DATA_WIDTH x DATA_WIDTH square with one register stage.
//   clk, rst : clock, asynchronous active-high reset
//   en       : load a*a into the output register (holds otherwise)
//   a        : operand
//   y        : registered square
module thd_sq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [DATA_WIDTH-1:0]     a,
    output logic [2*DATA_WIDTH-1:0]   y
);

    logic [2*DATA_WIDTH-1:0] a_ext_s;
    logic [2*DATA_WIDTH-1:0] sq_r;

    // Zero-extend so the product keeps its full double width.
    always_comb begin
        a_ext_s = {{DATA_WIDTH{1'b0}}, a};
    end

    // Square register, loaded only when a result is wanted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_r <= {(2*DATA_WIDTH){1'b0}};
        end else if (en) begin
            sq_r <= a_ext_s * a_ext_s;
        end else begin
            sq_r <= sq_r;
        end
    end

    assign y = sq_r;

endmodule

// File: rtl/thd_harm_scan.sv
// thd_harm_scan: sweeps the stored magnitude spectrum to find the fundamental,
// then scans a +/-WIN window around each harmonic k*f0 (k = 2..MAX_HARM,
// centres below N/2) and sums the squared window peaks.
//   rd_clk : sole clock (RAM read clock)
//   rd_rst : asynchronous active-high reset
//   bus    : request/result + RAM read port (thd_harm_scan_if.slave)
module thd_harm_scan
    import thd_pkg::*;
#(
    parameter int ADDR_WIDTH = THD_ADDR_WIDTH,
    parameter int DATA_WIDTH = THD_DATA_WIDTH,
    parameter int SEARCH_LO  = 2,
    parameter int MAX_HARM   = 10,
    parameter int WIN        = 1
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    thd_harm_scan_if.slave   bus
);

    localparam int CW    = ADDR_WIDTH + 1;   // centre width: c + WIN can pass N/2-1
    localparam int PW    = thd_pwr_width(DATA_WIDTH);
    localparam int ACC_W = thd_acc_width(DATA_WIDTH);

    localparam logic [CW-1:0]         HALF_N_C    = {2'b01, {(ADDR_WIDTH-1){1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] LAST_BIN_C  = {1'b0, {(ADDR_WIDTH-1){1'b1}}};
    localparam logic [ADDR_WIDTH-1:0] SEARCH_LO_C = ADDR_WIDTH'(SEARCH_LO);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE_C  = ADDR_WIDTH'(1);
    localparam logic [CW-1:0]         WIN_C       = CW'(WIN);
    localparam logic [3:0]            MAX_HARM_C  = 4'(MAX_HARM);

    thd_state_e              state_r;
    thd_state_e              next_s;

    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH-1:0]   end_r;
    logic [ADDR_WIDTH-1:0]   pend_addr_r;
    logic                    pend_r;
    logic                    drain_r;
    logic [DATA_WIDTH-1:0]   max_r;
    logic [ADDR_WIDTH-1:0]   max_idx_r;
    logic [ADDR_WIDTH-1:0]   f0_r;
    logic [CW-1:0]           c_r;
    logic [3:0]              k_r;
    logic [PW-1:0]           fund_pwr_r;
    logic [ACC_W-1:0]        acc_r;
    logic [3:0]              cnt_r;
    logic                    busy_r;
    logic                    done_r;
    logic [ADDR_WIDTH-1:0]   fund_bin_out_r;
    logic [PW-1:0]           fund_pwr_out_r;
    logic [ACC_W-1:0]        harm_pwr_out_r;
    logic [3:0]              harm_cnt_out_r;

    logic                    upd_s;
    logic [DATA_WIDTH-1:0]   max_next_s;
    logic [ADDR_WIDTH-1:0]   idx_next_s;
    logic [CW-1:0]           c_hi_s;
    logic [ADDR_WIDTH-1:0]   win_lo_s;
    logic [ADDR_WIDTH-1:0]   win_hi_s;
    logic                    stop_s;
    logic                    sq_en_s;
    logic [PW-1:0]           sq_s;

    // Peak tracking on returning data, harmonic window bounds and stop test.
    always_comb begin
        upd_s      = 1'b0;
        max_next_s = max_r;
        idx_next_s = max_idx_r;
        // Strict greater-than keeps the lowest index on ties.
        if (pend_r && (bus.rd_data > max_r)) begin
            upd_s = 1'b1;
        end else begin
            upd_s = 1'b0;
        end
        if (upd_s) begin
            max_next_s = bus.rd_data;
            idx_next_s = pend_addr_r;
        end else begin
            max_next_s = max_r;
            idx_next_s = max_idx_r;
        end
        c_hi_s   = c_r + WIN_C;
        win_lo_s = ADDR_WIDTH'(c_r - WIN_C);
        if (c_hi_s > {1'b0, LAST_BIN_C}) begin
            win_hi_s = LAST_BIN_C;
        end else begin
            win_hi_s = c_hi_s[ADDR_WIDTH-1:0];
        end
        stop_s = (c_r >= HALF_N_C) || (k_r > MAX_HARM_C);
    end

    // FSM state register.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next state; the squarer is loaded on the drain cycle of each sweep so the
    // square of the final maximum is ready in the following state.
    always_comb begin
        next_s  = state_r;
        sq_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    next_s = ST_FSCAN;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_FSCAN: begin
                if (drain_r) begin
                    next_s  = ST_FSQ;
                    sq_en_s = 1'b1;
                end else begin
                    next_s  = ST_FSCAN;
                end
            end
            ST_FSQ: begin
                next_s = ST_HSET;
            end
            ST_HSET: begin
                if (stop_s) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_HSCAN;
                end
            end
            ST_HSCAN: begin
                if (drain_r) begin
                    next_s  = ST_HACC;
                    sq_en_s = 1'b1;
                end else begin
                    next_s  = ST_HSCAN;
                end
            end
            ST_HACC: begin
                next_s = ST_HSET;
            end
            ST_DONE: begin
                next_s = ST_IDLE;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: address counter, peak tracker, harmonic accumulator, outputs.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            addr_r         <= {ADDR_WIDTH{1'b0}};
            end_r          <= {ADDR_WIDTH{1'b0}};
            pend_addr_r    <= {ADDR_WIDTH{1'b0}};
            pend_r         <= 1'b0;
            drain_r        <= 1'b0;
            max_r          <= {DATA_WIDTH{1'b0}};
            max_idx_r      <= {ADDR_WIDTH{1'b0}};
            f0_r           <= {ADDR_WIDTH{1'b0}};
            c_r            <= {CW{1'b0}};
            k_r            <= 4'd0;
            fund_pwr_r     <= {PW{1'b0}};
            acc_r          <= {ACC_W{1'b0}};
            cnt_r          <= 4'd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            fund_bin_out_r <= {ADDR_WIDTH{1'b0}};
            fund_pwr_out_r <= {PW{1'b0}};
            harm_pwr_out_r <= {ACC_W{1'b0}};
            harm_cnt_out_r <= 4'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_r    <= 1'b1;
                        addr_r    <= SEARCH_LO_C;
                        end_r     <= LAST_BIN_C;
                        max_r     <= {DATA_WIDTH{1'b0}};
                        max_idx_r <= SEARCH_LO_C;
                        pend_r    <= 1'b0;
                        drain_r   <= 1'b0;
                        acc_r     <= {ACC_W{1'b0}};
                        cnt_r     <= 4'd0;
                    end
                end
                ST_FSCAN, ST_HSCAN: begin
                    max_r     <= max_next_s;
                    max_idx_r <= idx_next_s;
                    if (drain_r) begin
                        // Last datum consumed above; rd_addr stays on the final bin.
                        pend_r  <= 1'b0;
                        drain_r <= 1'b0;
                    end else begin
                        pend_r      <= 1'b1;
                        pend_addr_r <= addr_r;
                        if (addr_r == end_r) begin
                            drain_r <= 1'b1;
                        end else begin
                            addr_r <= addr_r + ADDR_ONE_C;
                        end
                    end
                end
                ST_FSQ: begin
                    f0_r       <= max_idx_r;
                    fund_pwr_r <= sq_s;
                    c_r        <= {1'b0, max_idx_r} + {1'b0, max_idx_r};
                    k_r        <= 4'd2;
                end
                ST_HSET: begin
                    if (!stop_s) begin
                        addr_r  <= win_lo_s;
                        end_r   <= win_hi_s;
                        max_r   <= {DATA_WIDTH{1'b0}};
                        pend_r  <= 1'b0;
                        drain_r <= 1'b0;
                    end
                end
                ST_HACC: begin
                    acc_r <= acc_r + ACC_W'(sq_s);
                    cnt_r <= cnt_r + 4'd1;
                    k_r   <= k_r + 4'd1;
                    c_r   <= c_r + {1'b0, f0_r};
                end
                ST_DONE: begin
                    fund_bin_out_r <= f0_r;
                    fund_pwr_out_r <= fund_pwr_r;
                    harm_pwr_out_r <= acc_r;
                    harm_cnt_out_r <= cnt_r;
                    done_r         <= 1'b1;
                    busy_r         <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    thd_sq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sq (
        .clk (rd_clk),
        .rst (rd_rst),
        .en  (sq_en_s),
        .a   (max_next_s),
        .y   (sq_s)
    );

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.rd_addr  = addr_r;
    assign bus.fund_bin = fund_bin_out_r;
    assign bus.fund_pwr = fund_pwr_out_r;
    assign bus.harm_pwr = harm_pwr_out_r;
    assign bus.harm_cnt = harm_cnt_out_r;

endmodule
